// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter/sequencer: loader during BOOT, load/store and fetch in RUN.
// Optional macro ARB_STARVE_GUARD_EN bounds how long load/store can starve fetch.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [ADDR_W-1:0] ld_data,
    input  logic [1:0]        ld_size,
    input  logic              ld_done,
    input  logic              ld_error,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic              if_stall,
    input  logic              ls_req,
    input  logic              ls_rw,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [ADDR_W-1:0] ls_wdata,
    input  logic [1:0]        ls_size,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] mem_datain,
    output logic [1:0]        mem_size,
    output logic              mem_rw,
    input  logic [ADDR_W-1:0] mem_dataout,
    output logic [ADDR_W-1:0] rdata,
    output logic [ADDR_W-1:0] prog_end,
    output logic              halt,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_HALT  = 2'b10,
        ST_ERROR = 2'b11
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   prog_end_q, prog_end_d;
    logic [ADDR_W-1:0]   addr_q, wdata_q;
    logic [1:0]          size_q;
    logic [RD_LAT-1:0]   tag_v_q, tag_v_d;
    logic [RD_LAT-1:0]   tag_f_q, tag_f_d;
    logic                push_v, push_f;
    logic                fetch_force;

    if (RD_LAT < 1 || RD_LAT > 3 || STARVE_MAX < 1) begin : g_bad_param
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    logic [CNT_W-1:0] starve_q, starve_d;

    assign fetch_force = (starve_q == CNT_W'(STARVE_MAX)) && if_req;

    always_comb begin
        starve_d = starve_q;
        if (if_gnt)
            starve_d = '0;
        else if (ls_gnt && if_req)
            starve_d = starve_q + CNT_W'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) starve_q <= '0;
        else          starve_q <= starve_d;
    end
`else
    assign fetch_force = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        prog_end_d = prog_end_q;
        if_gnt     = 1'b0;
        ls_gnt     = 1'b0;
        if_stall   = 1'b1;
        halt       = 1'b0;
        mem_addr   = addr_q;
        mem_datain = wdata_q;
        mem_size   = size_q;
        mem_rw     = 1'b1;
        push_v     = 1'b0;
        push_f     = 1'b0;
        case (state_q)
            ST_BOOT: begin
                mem_addr   = ld_addr;
                mem_datain = ld_data;
                mem_size   = ld_size;
                mem_rw     = ~ld_valid;
                if (ld_valid && (ld_addr > prog_end_q))
                    prog_end_d = ld_addr;
                if (ld_error)
                    state_d = ST_ERROR;
                else if (ld_done)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (ls_req && !fetch_force) begin
                    ls_gnt     = 1'b1;
                    mem_addr   = ls_addr;
                    mem_datain = ls_wdata;
                    mem_size   = ls_size;
                    mem_rw     = ls_rw;
                    push_v     = ls_rw;
                end else if (if_req) begin
                    if_gnt   = 1'b1;
                    mem_addr = if_addr;
                    mem_size = 2'b11;
                    push_v   = 1'b1;
                    push_f   = 1'b1;
                    // The fetch at or past the program end is the last one served.
                    if (if_addr >= prog_end_q)
                        state_d = ST_HALT;
                end
                if_stall = ~if_gnt;
            end
            ST_HALT: begin
                halt = 1'b1;
            end
            default: begin
                halt       = 1'b1;
                mem_addr   = '0;
                mem_datain = '0;
                mem_size   = 2'b00;
            end
        endcase
        // Loader inputs reach the port combinationally, so mask them while in reset.
        if (!reset_n) begin
            if_gnt     = 1'b0;
            ls_gnt     = 1'b0;
            if_stall   = 1'b1;
            mem_addr   = '0;
            mem_datain = '0;
            mem_size   = 2'b00;
            mem_rw     = 1'b1;
            push_v     = 1'b0;
            push_f     = 1'b0;
        end
    end

    always_comb begin
        tag_v_d    = tag_v_q;
        tag_f_d    = tag_f_q;
        tag_v_d[0] = push_v;
        tag_f_d[0] = push_f;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_v_d[i] = tag_v_q[i-1];
            tag_f_d[i] = tag_f_q[i-1];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_BOOT;
            prog_end_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= 2'b00;
            tag_v_q    <= '0;
            tag_f_q    <= '0;
        end else begin
            state_q    <= state_d;
            prog_end_q <= prog_end_d;
            addr_q     <= mem_addr;
            wdata_q    <= mem_datain;
            size_q     <= mem_size;
            tag_v_q    <= tag_v_d;
            tag_f_q    <= tag_f_d;
        end
    end

    assign if_rvalid = tag_v_q[RD_LAT-1] & tag_f_q[RD_LAT-1];
    assign ls_rvalid = tag_v_q[RD_LAT-1] & ~tag_f_q[RD_LAT-1];
    assign rdata     = mem_dataout;
    assign prog_end  = prog_end_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (read latency 1 and 3) sharing stimulus,
// a behavioural memory, and a queue-based reference of grants and returned reads.
module tb_mem_port_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        ld_valid = 1'b0, ld_done = 1'b0, ld_error = 1'b0;
    logic [31:0] ld_addr = '0, ld_data = '0;
    logic [1:0]  ld_size = '0;
    logic        if_req = 1'b0, ls_req = 1'b0, ls_rw = 1'b1;
    logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
    logic [1:0]  ls_size = '0;

    logic        u1_if_gnt, u1_if_rvalid, u1_if_stall, u1_ls_gnt, u1_ls_rvalid, u1_mem_rw, u1_halt;
    logic [31:0] u1_mem_addr, u1_mem_datain, u1_rdata, u1_prog_end, dout_1;
    logic [1:0]  u1_mem_size, u1_state;
    logic        u3_if_gnt, u3_if_rvalid, u3_if_stall, u3_ls_gnt, u3_ls_rvalid, u3_mem_rw, u3_halt;
    logic [31:0] u3_mem_addr, u3_mem_datain, u3_rdata, u3_prog_end, dout_3;
    logic [1:0]  u3_mem_size, u3_state;

    mem_port_arbiter #(.ADDR_W(32), .RD_LAT(1), .STARVE_MAX(STARVE_MAX)) dut1 (
        .clock(clock), .reset_n(reset_n), .ld_valid(ld_valid), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_size(ld_size), .ld_done(ld_done), .ld_error(ld_error),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(u1_if_gnt), .if_rvalid(u1_if_rvalid),
        .if_stall(u1_if_stall), .ls_req(ls_req), .ls_rw(ls_rw), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_size(ls_size), .ls_gnt(u1_ls_gnt), .ls_rvalid(u1_ls_rvalid),
        .mem_addr(u1_mem_addr), .mem_datain(u1_mem_datain), .mem_size(u1_mem_size),
        .mem_rw(u1_mem_rw), .mem_dataout(dout_1), .rdata(u1_rdata), .prog_end(u1_prog_end),
        .halt(u1_halt), .state_o(u1_state)
    );

    mem_port_arbiter #(.ADDR_W(32), .RD_LAT(3), .STARVE_MAX(STARVE_MAX)) dut3 (
        .clock(clock), .reset_n(reset_n), .ld_valid(ld_valid), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_size(ld_size), .ld_done(ld_done), .ld_error(ld_error),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(u3_if_gnt), .if_rvalid(u3_if_rvalid),
        .if_stall(u3_if_stall), .ls_req(ls_req), .ls_rw(ls_rw), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_size(ls_size), .ls_gnt(u3_ls_gnt), .ls_rvalid(u3_ls_rvalid),
        .mem_addr(u3_mem_addr), .mem_datain(u3_mem_datain), .mem_size(u3_mem_size),
        .mem_rw(u3_mem_rw), .mem_dataout(dout_3), .rdata(u3_rdata), .prog_end(u3_prog_end),
        .halt(u3_halt), .state_o(u3_state)
    );

    always #5 clock = ~clock;

    // Behavioural memory: word array plus a read-data delay line (taps at 1 and 3 cycles).
    logic [31:0] sim_mem [0:255];
    logic [31:0] rd_pipe [0:2];
    always @(posedge clock) begin
        if (!u1_mem_rw) sim_mem[u1_mem_addr[9:2]] <= u1_mem_datain;
        rd_pipe[0] <= sim_mem[u1_mem_addr[9:2]];
        rd_pipe[1] <= rd_pipe[0];
        rd_pipe[2] <= rd_pipe[1];
    end
    assign dout_1 = rd_pipe[0];
    assign dout_3 = rd_pipe[2];

    typedef struct {
        int          due;
        bit          fetch;
        logic [31:0] data;
    } ret_t;

    // Reference model: 0 BOOT, 1 RUN, 2 HALT, 3 ERROR.
    int          m_state, m_starve, m_cycle;
    logic [31:0] m_prog_end, m_last_addr;
    logic [31:0] mem_ref [logic [31:0]];
    ret_t        q1[$], q3[$];
    int          n_tests, n_fail;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return mem_ref.exists(a) ? mem_ref[a] : 32'h0;
    endfunction

    task automatic model_reset();
        m_state     = 0;
        m_starve    = 0;
        m_prog_end  = '0;
        m_last_addr = '0;
        q1.delete();
        q3.delete();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ret(input string tag, ref ret_t q[$], input logic if_rv,
                           input logic ls_rv, input logic [31:0] rd);
        logic e_if, e_ls;
        e_if = (q.size() > 0) && (q[0].due == m_cycle) && q[0].fetch;
        e_ls = (q.size() > 0) && (q[0].due == m_cycle) && !q[0].fetch;
        chk({tag, "_if_rvalid"}, 32'(if_rv), 32'(e_if));
        chk({tag, "_ls_rvalid"}, 32'(ls_rv), 32'(e_ls));
        if (e_if || e_ls) chk({tag, "_rdata"}, rd, q[0].data);
    endtask

    // One clock cycle: check combinational outputs mid-cycle, then advance the model at the edge.
    task automatic tick();
        logic        e_if_gnt, e_ls_gnt, e_stall, e_rw, force_if;
        logic [31:0] e_addr;
        #1;
        if (!reset_n) model_reset();
        e_if_gnt = 1'b0;
        e_ls_gnt = 1'b0;
        e_stall  = 1'b1;
        e_rw     = 1'b1;
        e_addr   = m_last_addr;
        force_if = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
        force_if = (m_starve == STARVE_MAX) && if_req;
`endif
        if (!reset_n) begin
            e_addr = '0;
        end else if (m_state == 0) begin
            e_rw   = ~ld_valid;
            e_addr = ld_addr;
        end else if (m_state == 1) begin
            if (ls_req && !force_if) begin
                e_ls_gnt = 1'b1;
                e_rw     = ls_rw;
                e_addr   = ls_addr;
            end else if (if_req) begin
                e_if_gnt = 1'b1;
                e_addr   = if_addr;
            end
            e_stall = ~e_if_gnt;
        end else if (m_state == 3) begin
            e_addr = '0;
        end
        chk("state", 32'(u1_state), 32'(m_state));
        chk("state_lat3", 32'(u3_state), 32'(m_state));
        chk("prog_end", u1_prog_end, m_prog_end);
        chk("halt", 32'(u1_halt), 32'(m_state >= 2 && reset_n));
        chk("if_gnt", 32'(u1_if_gnt), 32'(e_if_gnt));
        chk("ls_gnt", 32'(u1_ls_gnt), 32'(e_ls_gnt));
        chk("if_stall", 32'(u1_if_stall), 32'(e_stall));
        chk("mem_rw", 32'(u1_mem_rw), 32'(e_rw));
        chk("mem_addr", u1_mem_addr, e_addr);
        chk("mem_addr_lat3", u3_mem_addr, e_addr);
        if (e_ls_gnt && !ls_rw) chk("mem_datain", u1_mem_datain, ls_wdata);
        if (e_if_gnt) chk("mem_size_fetch", 32'(u1_mem_size), 32'h3);
        chk_ret("lat1", q1, u1_if_rvalid, u1_ls_rvalid, u1_rdata);
        chk_ret("lat3", q3, u3_if_rvalid, u3_ls_rvalid, u3_rdata);
        @(posedge clock);
        if (!reset_n) begin
            model_reset();
        end else begin
            if (m_state == 0) begin
                if (ld_valid) begin
                    mem_ref[ld_addr] = ld_data;
                    if (ld_addr > m_prog_end) m_prog_end = ld_addr;
                end
                if (ld_error) m_state = 3;
                else if (ld_done) m_state = 1;
            end else if (m_state == 1) begin
                if (e_ls_gnt && ls_rw) begin
                    q1.push_back('{m_cycle + 1, 1'b0, ref_rd(ls_addr)});
                    q3.push_back('{m_cycle + 3, 1'b0, ref_rd(ls_addr)});
                end else if (e_ls_gnt) begin
                    mem_ref[ls_addr] = ls_wdata;
                end
                if (e_if_gnt) begin
                    q1.push_back('{m_cycle + 1, 1'b1, ref_rd(if_addr)});
                    q3.push_back('{m_cycle + 3, 1'b1, ref_rd(if_addr)});
                    if (if_addr >= m_prog_end) m_state = 2;
                end
                if (e_if_gnt) m_starve = 0;
                else if (e_ls_gnt && if_req) m_starve++;
            end
            m_last_addr = e_addr;
            while (q1.size() > 0 && q1[0].due <= m_cycle) void'(q1.pop_front());
            while (q3.size() > 0 && q3[0].due <= m_cycle) void'(q3.pop_front());
        end
        m_cycle++;
        @(negedge clock);
    endtask

    task automatic load_word(input logic [31:0] a);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = $urandom;
        ld_size  = 2'b11;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic boot_program();
        logic [31:0] addrs [4];
        addrs = '{32'h0, 32'h4, 32'h1C, 32'h8};
        for (int i = 0; i < 4; i++) load_word(addrs[i]);
        ld_addr = $urandom;
        tick();
        ld_done = 1'b1;
        tick();
        ld_done = 1'b0;
    endtask

    initial begin
        int pc;
        n_tests = 0;
        n_fail  = 0;
        m_cycle = 0;
        model_reset();
        for (int i = 0; i < 256; i++) sim_mem[i] = '0;
        #1 reset_n = 1'b0;
        @(negedge clock);
        tick();
        tick();
        reset_n = 1'b1;

        // Boot: highest loaded address becomes the program end.
        boot_program();
        chk("prog_end_after_boot", u1_prog_end, 32'h1C);
        chk("state_run_after_done", 32'(u1_state), 32'h1);

        // Same-cycle conflict: load/store wins, fetch follows next cycle.
        ls_req = 1'b1; ls_rw = 1'b1; ls_addr = 32'h8; ls_size = 2'b11;
        if_req = 1'b1; if_addr = 32'h0;
        tick();
        ls_req = 1'b0;
        tick();
        if_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // Both requesters held continuously.
        ls_req = 1'b1; ls_rw = 1'b1; if_req = 1'b1; if_addr = 32'h4;
        for (int i = 0; i < 15; i++) begin
            ls_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            tick();
        end

        // Random traffic; fetch stays below the program end, loader beats must be ignored.
        for (int i = 0; i < 300; i++) begin
            ls_req   = 1'($urandom_range(0, 1));
            ls_rw    = 1'($urandom_range(0, 1));
            ls_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            ls_wdata = $urandom;
            ls_size  = 2'($urandom_range(0, 3));
            if_req   = 1'($urandom_range(0, 1));
            if_addr  = {27'h0, 3'($urandom_range(0, 6)), 2'b00};
            ld_valid = 1'($urandom_range(0, 1));
            ld_addr  = $urandom;
            tick();
        end
        ls_req = 1'b0; if_req = 1'b0; ld_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // Sequential fetch stream up to the program end, then HALT with data drained.
        if_req = 1'b1;
        pc = 0;
        for (int i = 0; i < 16 && m_state == 1; i++) begin
            if_addr = 32'(pc);
            tick();
            pc += 4;
        end
        ls_req = 1'b1; ls_rw = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("halt_after_end_fetch", 32'(u1_halt), 32'h1);
        ls_req = 1'b0; if_req = 1'b0;

        // Reset one cycle after a read grant: no return may appear.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        boot_program();
        ls_req = 1'b1; ls_rw = 1'b1; ls_addr = 32'h4;
        tick();
        ls_req = 1'b0;
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("state_boot_after_reset", 32'(u3_state), 32'h0);
        chk("prog_end_after_reset", u3_prog_end, 32'h0);
        reset_n = 1'b1;
        tick();

        // Loader error together with done: error wins and the port stays idle.
        ld_error = 1'b1; ld_done = 1'b1;
        tick();
        ld_error = 1'b0; ld_done = 1'b0;
        if_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if_addr = {27'h0, 3'($urandom_range(0, 7)), 2'b00};
            ls_req  = 1'($urandom_range(0, 1));
            tick();
        end
        chk("halt_in_error", 32'(u1_halt), 32'h1);
        if_req = 1'b0; ls_req = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Single-port arbiter and sequencer for the unified instruction/data memory.
- Three requesters share the port: the S-record loader during boot, and the fetch stage and load/store stage at run time.
- Sequences boot to run, tracks the highest loaded address as the program end, and generates fetch stall/halt.
- Returns read data to the correct owner after the fixed memory read latency.

Parameters:
- ADDR_W, 32, address and data width.
- RD_LAT, 1, cycles from address presented to memory dataout valid (1..3).
- STARVE_MAX, 4, maximum consecutive data grants before fetch is forced (optional feature only).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ld_valid  in  1  loader write beat valid.
- ld_addr  in  ADDR_W  loader write address.
- ld_data  in  ADDR_W  loader write data.
- ld_size  in  2  loader access size.
- ld_done  in  1  loader finished (level).
- ld_error  in  1  loader parse error (level).
- if_req  in  1  fetch read request.
- if_addr  in  ADDR_W  fetch address (PC).
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_stall  out  1  stall to fetch stage.
- ls_req  in  1  load/store request.
- ls_rw  in  1  1 = read, 0 = write.
- ls_addr  in  ADDR_W  load/store address.
- ls_wdata  in  ADDR_W  store data.
- ls_size  in  2  load/store access size.
- ls_gnt  out  1  load/store accepted this cycle.
- ls_rvalid  out  1  load data valid.
- mem_addr  out  ADDR_W  memory address.
- mem_datain  out  ADDR_W  memory write data.
- mem_size  out  2  memory access size.
- mem_rw  out  1  1 = read, 0 = write.
- mem_dataout  in  ADDR_W  memory read data.
- rdata  out  ADDR_W  mem_dataout forwarded to both owners.
- prog_end  out  ADDR_W  highest loader address written.
- halt  out  1  program finished or loader error.
- state_o  out  2  00 BOOT, 01 RUN, 10 HALT, 11 ERROR.

Behaviour:
- Reset (async, reset_n = 0):
  - State BOOT; all gnt/rvalid = 0; if_stall = 1; halt = 0; prog_end = 0; read-tag pipe cleared.
  - mem_rw = 1, mem_addr = 0, mem_datain = 0, mem_size = 0.
- BOOT:
  - Memory port driven combinationally from ld_*; mem_rw = ~ld_valid.
  - if_gnt = 0, ls_gnt = 0, if_stall = 1.
  - On each ld_valid cycle with ld_addr > prog_end (unsigned), prog_end <= ld_addr.
  - ld_error → ERROR next cycle (error takes precedence over ld_done in the same cycle).
  - ld_done → RUN next cycle.
- RUN, one grant per cycle:
  - Priority: ls_req over if_req.
  - Granted requester's address/size/rw drive the memory combinationally; gnt is asserted the same cycle.
  - Fetch is always a read; mem_size = 2'b11 (word).
  - No grant: mem_rw = 1, address held.
  - if_stall = ~if_gnt.
- Read return:
  - Each granted read pushes an owner tag {valid, is_fetch} into an RD_LAT-deep shift pipe.
  - When the tag exits, assert if_rvalid or ls_rvalid for exactly 1 cycle; rdata = mem_dataout.
  - Writes push an invalid tag.
  - Reads may be back-to-back every cycle; there are no bubbles.
- Halt:
  - In RUN, if a fetch is granted with if_addr >= prog_end → HALT next cycle.
  - That fetch is still granted and its data is returned.
  - HALT: halt = 1, no further grants, pending tags drain normally; HALT is exited only by reset.
- ERROR: halt = 1, if_stall = 1, no grants, and the memory port is idle (read at address 0).
- ld_valid outside BOOT is ignored.
- prog_end is frozen after BOOT.
- Reset mid-operation: all in-flight tags are discarded and no rvalid is produced.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - A counter increments on each ls grant made while if_req = 1; it clears on any if grant.
  - When the count equals STARVE_MAX and if_req = 1, fetch wins over ls for that cycle.
- Undefined: strict ls priority; fetch can starve indefinitely; the counter is not instantiated.

Test Plan:
- Boot: load words at 0x0, 0x4, 0x1C, 0x8, then ld_done → prog_end = 0x1C; state RUN one cycle after ld_done; if_stall = 1 throughout BOOT.
- RUN fetch stream, RD_LAT = 1: if_req held, PC 0x0, 0x4, … → if_gnt every cycle; if_rvalid 1 cycle later with the loaded data; grant at 0x1C → halt = 1 next cycle, last data still returned.
- Conflict: ls_req (read 0x8) and if_req in the same cycle → ls_gnt = 1, if_gnt = 0, if_stall = 1; next cycle if_gnt = 1; ls_rvalid and if_rvalid in consecutive cycles, no tag mixup.
- Error: ld_error and ld_done together in BOOT → ERROR, halt = 1, no grants for 20 cycles despite if_req = 1.
- Reset mid-read, RD_LAT = 3: deassert reset_n 1 cycle after a grant → no rvalid; state BOOT; prog_end = 0.
- With ARB_STARVE_GUARD_EN, STARVE_MAX = 4: ls_req and if_req held → grant pattern ls, ls, ls, ls, if, repeating.
